// File: rtl/v_shift_serializer_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | v_shift_serializer_if : word-in / bit-out bundle of the serializer     |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
interface v_shift_serializer_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] din;
  logic             din_valid;
  logic             din_ready;
  logic             flush;
  logic             SO;
  logic             so_en;
  logic             busy;
  logic             done;

  modport master (
    output din, din_valid, flush,
    input  din_ready, SO, so_en, busy, done
  );

  modport slave (
    input  din, din_valid, flush,
    output din_ready, SO, so_en, busy, done
  );
endinterface
`default_nettype wire

// File: rtl/v_shift_serializer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | v_shift_serializer : parallel word to SI/clken stream for a shift reg |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module v_shift_serializer #(
  parameter int WIDTH     = 8,
  parameter int DIV       = 1,
  parameter int MSB_FIRST = 1
) (
  input  wire logic           clk,
  input  wire logic           rst_n,
  v_shift_serializer_if.slave bus
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DW-1:0] c_div_reload = DW'(DIV - 1);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic [CW-1:0]    bcnt_q, bcnt_d;
  logic [DW-1:0]    div_q, div_d;
  logic             done_q, done_d;

  logic             w_strobe;
  logic             w_last;
  logic             w_ready;
  logic             w_accept;
  logic             w_out_bit;
  logic [WIDTH-1:0] w_shifted;

  generate
    if (MSB_FIRST != 0) begin : g_msb_first
      assign w_out_bit = sreg_q[WIDTH-1];
      assign w_shifted = {sreg_q[WIDTH-2:0], 1'b0};
    end else begin : g_lsb_first
      assign w_out_bit = sreg_q[0];
      assign w_shifted = {1'b0, sreg_q[WIDTH-1:1]};
    end
  endgenerate

  // Ready is gated by rst_n so it is low for the whole reset window.
  always_comb begin
    w_strobe = (state_q == SHIFT) && (div_q == '0) && !bus.flush;
    w_last   = w_strobe && (bcnt_q == CW'(1));
    w_ready  = rst_n && ((state_q == IDLE) ? !bus.flush : w_last);
    w_accept = w_ready && bus.din_valid;
  end

  always_comb begin
    state_d = state_q;
    sreg_d  = sreg_q;
    bcnt_d  = bcnt_q;
    div_d   = div_q;
    done_d  = w_last;
    case (state_q)
      IDLE: begin
        if (w_accept) begin
          sreg_d  = bus.din;
          bcnt_d  = CW'(WIDTH);
          div_d   = c_div_reload;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (bus.flush) begin
          state_d = IDLE;
          sreg_d  = '0;
          bcnt_d  = '0;
          div_d   = '0;
        end else if (div_q != '0) begin
          div_d = div_q - DW'(1);
        end else begin
          sreg_d = w_shifted;
          bcnt_d = (bcnt_q != '0) ? bcnt_q - CW'(1) : '0;
          div_d  = c_div_reload;
          // A word taken on the last strobe keeps the strobe cadence unbroken.
          if (w_last) begin
            if (w_accept) begin
              sreg_d = bus.din;
              bcnt_d = CW'(WIDTH);
            end else begin
              state_d = IDLE;
            end
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sreg_q  <= '0;
      bcnt_q  <= '0;
      div_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      bcnt_q  <= bcnt_d;
      div_q   <= div_d;
      done_q  <= done_d;
    end
  end

  assign bus.din_ready = w_ready;
  assign bus.so_en     = w_strobe;
  assign bus.busy      = (state_q == SHIFT);
  assign bus.SO        = (state_q == SHIFT) && w_out_bit;
  assign bus.done      = done_q;

endmodule
`default_nettype wire

// File: tb/tb_v_shift_serializer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_v_shift_serializer : three parameterisations driven one at a time  |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module tb_v_shift_serializer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] din = '0;
  logic       din_valid = 1'b0;
  logic       flush = 1'b0;
  int         sel = 0;

  logic [2:0] t_rdy, t_so, t_soen, t_busy, t_done;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Instance 0: DIV=1 MSB-first, 1: DIV=4 MSB-first, 2: DIV=1 LSB-first.
  for (genvar k = 0; k < 3; k++) begin : g_dut
    localparam int P_DIV = (k == 1) ? 4 : 1;
    localparam int P_MSB = (k == 2) ? 0 : 1;

    v_shift_serializer_if #(.WIDTH(8)) bus ();

    assign bus.din       = din;
    assign bus.din_valid = din_valid && (sel == k);
    assign bus.flush     = flush && (sel == k);
    assign t_rdy[k]      = bus.din_ready;
    assign t_so[k]       = bus.SO;
    assign t_soen[k]     = bus.so_en;
    assign t_busy[k]     = bus.busy;
    assign t_done[k]     = bus.done;

    v_shift_serializer #(.WIDTH(8), .DIV(P_DIV), .MSB_FIRST(P_MSB)) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
    );

    // Scoreboard: words pushed on acceptance, bits checked per strobe,
    // downstream register compared against the word on done.
    logic [7:0] q[$];
    logic [7:0] ds, done_word, w;
    int         bitidx, gap;
    bit         exp_done;
    bit         exp_bit;

    initial begin
      ds = '0; done_word = '0; bitidx = 0; gap = 0; exp_done = 0;
      forever begin
        @(negedge clk);
        if (!rst_n) begin
          q.delete();
          bitidx = 0; gap = 0; exp_done = 0;
        end else begin
          if (bus.done || exp_done) begin
            chk(bus.done == exp_done, "mon_done", bus.done, exp_done);
            if (bus.done && exp_done)
              chk(ds == done_word, "mon_downstream", ds, done_word);
          end
          exp_done = 0;
          gap++;
          if (bus.flush && bus.busy) begin
            chk(bus.so_en == 1'b0, "mon_flush_so_en", bus.so_en, 0);
            if (q.size() > 0) void'(q.pop_front());
            bitidx = 0;
          end else if (bus.so_en) begin
            if (q.size() == 0) begin
              chk(1'b0, "mon_spurious_so_en", 1, 0);
            end else begin
              w = q[0];
              exp_bit = (P_MSB != 0) ? w[7 - bitidx] : w[bitidx];
              chk(bus.SO == exp_bit, "mon_so", bus.SO, exp_bit);
              chk(gap == P_DIV, "mon_strobe_gap", gap, P_DIV);
              ds = (P_MSB != 0) ? {ds[6:0], bus.SO} : {bus.SO, ds[7:1]};
              bitidx++;
              if (bitidx == 8) begin
                done_word = q.pop_front();
                exp_done = 1;
                bitidx = 0;
              end
            end
            gap = 0;
          end
          if (bus.din_valid && bus.din_ready) begin
            q.push_back(bus.din);
            gap = 0;
          end
        end
      end
    end
  end

  task automatic send(input int s, input logic [7:0] word, output logic [7:0] bits,
                      output int busy_n, output int nstr, output int first_at);
    bit got;
    int n;
    bits = '0; busy_n = 0; nstr = 0; first_at = 0;
    @(posedge clk); #1;
    sel = s; din = word; din_valid = 1'b1;
    got = 0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      if (t_rdy[s]) got = 1;
    end
    @(posedge clk); #1;
    din_valid = 1'b0;
    if (!got) begin
      chk(1'b0, "accept_timeout", 0, 1);
      return;
    end
    got = 0; n = 0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      n++;
      if (t_busy[s]) busy_n++;
      if (t_soen[s]) begin
        bits = {bits[6:0], t_so[s]};
        nstr++;
        if (nstr == 1) first_at = n;
      end
      if (t_done[s]) got = 1;
    end
    if (!got) chk(1'b0, "done_timeout", 0, 1);
  endtask

  task automatic wait_accept(input int s);
    bit got;
    got = 0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      if (t_rdy[s] && din_valid) got = 1;
    end
    @(posedge clk); #1;
    din_valid = 1'b0;
    if (!got) chk(1'b0, "accept_timeout", 0, 1);
  endtask

  task automatic wait_strobes(input int s, input int cnt);
    int c;
    c = 0;
    for (int i = 0; i < 100 && c < cnt; i++) begin
      @(negedge clk);
      if (t_soen[s]) c++;
    end
    if (c < cnt) chk(1'b0, "strobe_timeout", c, cnt);
  endtask

  typedef struct {
    int         s;
    logic [7:0] w;
    logic [7:0] bits;
    int         busy_n;
    int         first_at;
  } vec_t;

  vec_t tbl[6];

  initial begin
    logic [7:0] bits;
    int busy_n, nstr, first_at, cnt_en, cnt_dn;
    int str[$], acc[$], dn[$];

    // bits packs SO in strobe order, first strobe in bit 7.
    tbl[0] = '{0, 8'hA5, 8'hA5, 8,  1};
    tbl[1] = '{0, 8'h3C, 8'h3C, 8,  1};
    tbl[2] = '{1, 8'h81, 8'h81, 32, 4};
    tbl[3] = '{1, 8'h5A, 8'h5A, 32, 4};
    tbl[4] = '{2, 8'h01, 8'h80, 8,  1};
    tbl[5] = '{2, 8'hB4, 8'h2D, 8,  1};

    repeat (3) @(posedge clk);
    #1;
    chk({t_busy, t_soen, t_done, t_so, t_rdy} == '0, "reset_outputs",
        {t_busy, t_soen, t_done, t_so, t_rdy}, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk(t_rdy == 3'b111, "ready_after_reset", t_rdy, 3'b111);
    chk(t_busy == 3'b000, "idle_after_reset", t_busy, 0);

    for (int i = 0; i < 6; i++) begin
      send(tbl[i].s, tbl[i].w, bits, busy_n, nstr, first_at);
      chk(bits == tbl[i].bits, "vec_so_bits", bits, tbl[i].bits);
      chk(busy_n == tbl[i].busy_n, "vec_busy_cycles", busy_n, tbl[i].busy_n);
      chk(nstr == 8, "vec_strobes", nstr, 8);
      chk(first_at == tbl[i].first_at, "vec_first_strobe", first_at, tbl[i].first_at);
    end

    // Back-to-back words with din_valid held.
    @(posedge clk); #1;
    sel = 0; din = 8'h3C; din_valid = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (t_soen[0]) str.push_back(i);
      if (t_done[0]) dn.push_back(i);
      if (din_valid && t_rdy[0]) acc.push_back(i);
      @(posedge clk); #1;
      if (acc.size() >= 1) din = 8'hC3;
      if (acc.size() >= 2) din_valid = 1'b0;
    end
    chk(str.size() == 16, "b2b_strobe_count", str.size(), 16);
    if (str.size() == 16) begin
      chk(str[15] - str[0] == 15, "b2b_no_gap", str[15] - str[0], 15);
      chk(acc.size() == 2 && acc[acc.size()-1] == str[7], "b2b_second_accept",
          acc[acc.size()-1], str[7]);
      chk(dn.size() == 2 && dn[0] == str[7] + 1, "b2b_first_done", dn[0], str[7] + 1);
    end
    chk(dn.size() == 2 && dn[dn.size()-1] - dn[0] == 8, "b2b_done_spacing",
        dn[dn.size()-1] - dn[0], 8);

    // Flush after the third strobe.
    @(posedge clk); #1;
    sel = 0; din = 8'hFF; din_valid = 1'b1;
    wait_accept(0);
    wait_strobes(0, 3);
    @(posedge clk); #1;
    flush = 1'b1;
    @(negedge clk);
    chk(t_soen[0] == 1'b0, "flush_so_en", t_soen[0], 0);
    chk(t_rdy[0] == 1'b0, "flush_ready", t_rdy[0], 0);
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    chk(t_busy[0] == 1'b0, "flush_idle", t_busy[0], 0);
    chk(t_rdy[0] == 1'b1, "flush_ready_after", t_rdy[0], 1);
    cnt_en = 0; cnt_dn = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (t_soen[0]) cnt_en++;
      if (t_done[0]) cnt_dn++;
    end
    chk(cnt_en == 0, "flush_no_strobe", cnt_en, 0);
    chk(cnt_dn == 0, "flush_no_done", cnt_dn, 0);

    // Flush and din_valid together in IDLE: nothing accepted.
    @(posedge clk); #1;
    flush = 1'b1; din = 8'h55; din_valid = 1'b1;
    @(negedge clk);
    chk(t_rdy[0] == 1'b0, "flush_valid_ready", t_rdy[0], 0);
    @(posedge clk); #1;
    flush = 1'b0; din_valid = 1'b0;
    @(negedge clk);
    chk(t_busy[0] == 1'b0, "flush_valid_no_accept", t_busy[0], 0);

    // Reset after the fifth strobe.
    @(posedge clk); #1;
    sel = 0; din = 8'h96; din_valid = 1'b1;
    wait_accept(0);
    wait_strobes(0, 5);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk({t_busy[0], t_soen[0], t_done[0], t_so[0], t_rdy[0]} == '0, "midreset_async",
        {t_busy[0], t_soen[0], t_done[0], t_so[0], t_rdy[0]}, 0);
    @(negedge clk);
    chk({t_busy[0], t_soen[0], t_done[0], t_so[0], t_rdy[0]} == '0, "midreset_hold",
        {t_busy[0], t_soen[0], t_done[0], t_so[0], t_rdy[0]}, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk(t_rdy[0] == 1'b1, "midreset_ready", t_rdy[0], 1);
    cnt_en = 0; cnt_dn = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (t_soen[0]) cnt_en++;
      if (t_done[0]) cnt_dn++;
    end
    chk(cnt_en == 0 && cnt_dn == 0, "midreset_silent", cnt_en + cnt_dn, 0);
    send(0, 8'h6B, bits, busy_n, nstr, first_at);
    chk(bits == 8'h6B, "midreset_next_word", bits, 8'h6B);

    repeat (4) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    fails++;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
